// File: rtl/burrito_pkg.sv
// Shared definitions for the burrito datapath.
//   - Bit positions of the fields in the 20-bit instruction word.
//   - ALU opcode enumeration. Codes 12..15 are undefined: they produce a
//     zero result and never write back.
package burrito_pkg;

  localparam int unsigned WE_BIT = 19;
  localparam int unsigned OP_HI  = 18;
  localparam int unsigned OP_LO  = 15;
  localparam int unsigned D1_HI  = 14;
  localparam int unsigned D1_LO  = 10;
  localparam int unsigned D2_HI  = 9;
  localparam int unsigned D2_LO  = 5;
  localparam int unsigned RD_HI  = 4;
  localparam int unsigned RD_LO  = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_PASS = 4'd11
  } alu_op_t;

endpackage

// File: rtl/burrito_regfile.sv
// Register file for the burrito datapath: 2**ADDR_W x DATA_W entries.
// Two asynchronous read ports and one synchronous write port. A synchronous
// active-low reset loads every register with its own index and blocks any
// write in that cycle.
// Optional build macro ZERO_REG_EN: register 0 reads as zero and ignores
// writes (its reset value is 0 in either build).
// Ports:
//   clk       in  clock, writes and reset on rising edge
//   rst_n     in  synchronous active-low reset
//   i_we      in  write enable
//   i_waddr   in  write address
//   i_wdata   in  write data
//   i_raddr1  in  read address, port 1
//   i_raddr2  in  read address, port 2
//   o_rdata1  out read data, port 1 (combinational)
//   o_rdata2  out read data, port 2 (combinational)
module burrito_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr;

`ifdef ZERO_REG_EN
  assign w_wr     = i_we && (i_waddr != '0);
  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`else
  assign w_wr     = i_we;
  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= DATA_W'(i);
      end
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/burrito.sv
// Single-cycle register-file + ALU datapath driven by a 20-bit instruction.
// Each cycle the instruction is decoded, two registers are read, the ALU
// result is formed combinationally and, when enabled and the opcode is
// defined, written to RD on the next rising edge.
// Optional build macro ZERO_REG_EN (handled in burrito_regfile): register 0
// is hard-wired to zero.
// Ports:
//   clk           in  clock
//   rst_n         in  synchronous active-low reset
//   Instructions  in  [19]=WEnable [18:15]=Op [14:10]=D1 [9:5]=D2 [4:0]=RD
//   rd1_data      out regs[D1] (combinational)
//   rd2_data      out regs[D2] (combinational)
//   alu_result    out ALU output (combinational)
//   zero          out alu_result == 0
module burrito
  import burrito_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [19:0]       Instructions,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero
);

  logic              w_we;
  logic [OP_W-1:0]   w_op;
  logic [ADDR_W-1:0] w_d1;
  logic [ADDR_W-1:0] w_d2;
  logic [ADDR_W-1:0] w_rd;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_alu;
  logic              w_op_valid;

  assign w_we    = Instructions[WE_BIT];
  assign w_op    = Instructions[OP_HI:OP_LO];
  assign w_d1    = Instructions[D1_HI:D1_LO];
  assign w_d2    = Instructions[D2_HI:D2_LO];
  assign w_rd    = Instructions[RD_HI:RD_LO];
  assign w_shamt = rd2_data[4:0];

  burrito_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we && w_op_valid),
    .i_waddr  (w_rd),
    .i_wdata  (w_alu),
    .i_raddr1 (w_d1),
    .i_raddr2 (w_d2),
    .o_rdata1 (rd1_data),
    .o_rdata2 (rd2_data)
  );

  // Undefined opcodes fall to the default arm, which also suppresses writeback.
  always_comb begin
    w_alu      = '0;
    w_op_valid = 1'b1;
    case (alu_op_t'(w_op))
      OP_ADD:  w_alu = rd1_data + rd2_data;
      OP_SUB:  w_alu = rd1_data - rd2_data;
      OP_AND:  w_alu = rd1_data & rd2_data;
      OP_OR:   w_alu = rd1_data | rd2_data;
      OP_XOR:  w_alu = rd1_data ^ rd2_data;
      OP_NOR:  w_alu = ~(rd1_data | rd2_data);
      OP_SLT:  w_alu = DATA_W'($signed(rd1_data) < $signed(rd2_data));
      OP_SLTU: w_alu = DATA_W'(rd1_data < rd2_data);
      OP_SLL:  w_alu = rd1_data << w_shamt;
      OP_SRL:  w_alu = rd1_data >> w_shamt;
      OP_SRA:  w_alu = $signed(rd1_data) >>> w_shamt;
      OP_PASS: w_alu = rd1_data;
      default: begin
        w_alu      = '0;
        w_op_valid = 1'b0;
      end
    endcase
  end

  assign alu_result = w_alu;
  assign zero       = (w_alu == '0);

endmodule

// File: tb/tb_burrito.sv
module tb_burrito;

  logic        clk;
  logic        rst_n;
  logic [19:0] Instructions;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic [31:0] alu_result;
  logic        zero;

  int unsigned n_checks;
  int unsigned n_pass;

  logic [31:0] model [32];

  burrito #(
    .DATA_W (32),
    .ADDR_W (5),
    .OP_W   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Instructions (Instructions),
    .rd1_data     (rd1_data),
    .rd2_data     (rd2_data),
    .alu_result   (alu_result),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [19:0] mk(input int we, input int op, input int d1, input int d2, input int rd);
    logic [19:0] w;
    w = {we[0], op[3:0], d1[4:0], d2[4:0], rd[4:0]};
    return w;
  endfunction

  function automatic logic [31:0] mread(input int idx);
`ifdef ZERO_REG_EN
    if (idx == 0) return 32'd0;
`endif
    return model[idx];
  endfunction

  // Reference ALU computed from arithmetic definitions of each operation.
  function automatic logic [31:0] mref(input int op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int sh;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      0:  r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      1:  r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b);
      6:  r = (sa < sb) ? 32'd1 : 32'd0;
      7:  r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
      8:  r = 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      9:  r = 32'(64'(a) / (64'd1 << sh));
      10: r = 32'((sa >= 0 ? sa / (64'sd1 <<< sh)
                           : -((-sa + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh))));
      11: r = a;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 32; i++) model[i] = 32'(i);
  endfunction

  // Apply one instruction for one clock edge, compare all outputs before the
  // edge, then advance the reference model.
  task automatic step(input logic [19:0] instr, input logic rst_v, input string tag);
    int op, d1, d2, rd;
    logic [31:0] a, b, r;
    @(negedge clk);
    Instructions = instr;
    rst_n = rst_v;
    #1;
    op = int'(instr[18:15]);
    d1 = int'(instr[14:10]);
    d2 = int'(instr[9:5]);
    rd = int'(instr[4:0]);
    a = mread(d1);
    b = mread(d2);
    r = mref(op, a, b);
    check({tag, "_rd1"}, rd1_data, a);
    check({tag, "_rd2"}, rd2_data, b);
    check({tag, "_alu"}, alu_result, r);
    check({tag, "_zero"}, 32'(zero), (r == 32'd0) ? 32'd1 : 32'd0);
    @(posedge clk);
    if (!rst_v) mreset();
    else if (instr[19] && op < 12) model[rd] = r;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0;
    Instructions = '0;
    @(posedge clk);
    mreset();

    // Reset values and PASS
    step(mk(0, 11, 3, 4, 0), 1'b1, "t1");
    check("t1_const_alu", alu_result, 32'd3);
    // ADD writeback
    step(mk(1, 0, 3, 4, 10), 1'b1, "t2");
    step(mk(0, 11, 10, 0, 0), 1'b1, "t2_rb");
    check("t2_const_r10", rd1_data, 32'd7);
    // SUB, no write
    step(mk(0, 1, 5, 7, 2), 1'b1, "t3");
    step(mk(0, 11, 2, 0, 0), 1'b1, "t3_rb");
    check("t3_const_r2", rd1_data, 32'd2);
    // signed vs unsigned compare on all-ones
    step(mk(1, 1, 0, 1, 9), 1'b1, "t4_mk");
    step(mk(0, 6, 9, 1, 0), 1'b1, "t4_slt");
    check("t4_const_slt", alu_result, 32'd1);
    step(mk(0, 7, 9, 1, 0), 1'b1, "t4_sltu");
    check("t4_const_sltu", alu_result, 32'd0);
    // read-during-write on same register
    step(mk(1, 0, 1, 1, 1), 1'b1, "t5_a");
    step(mk(1, 0, 1, 1, 1), 1'b1, "t5_b");
    check("t5_const_alu", alu_result, 32'd4);
    step(mk(0, 11, 1, 1, 0), 1'b1, "t5_rb");
    check("t5_const_r1", rd1_data, 32'd4);
    // write to register 0, then read it
    step(mk(1, 0, 3, 3, 0), 1'b1, "t6_w0");
    step(mk(0, 11, 0, 0, 0), 1'b1, "t6_r0");
    // undefined opcode with write enabled
    step(mk(1, 13, 3, 4, 5), 1'b1, "t6_op13");
    step(mk(0, 11, 5, 0, 0), 1'b1, "t6_r5");
    check("t6_const_r5", rd1_data, 32'd5);
    // reset overrides a simultaneous write
    step(mk(1, 0, 3, 4, 6), 1'b0, "t7_rst");
    step(mk(0, 11, 6, 0, 0), 1'b1, "t7_r6");
    check("t7_const_r6", rd1_data, 32'd6);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [19:0] ins;
      logic rv;
      ins = 20'($urandom);
      rv = ($urandom_range(0, 59) != 0);
      step(ins, rv, "rnd");
    end

    // sweep every register against the model
    for (int i = 0; i < 32; i += 2) begin
      step(mk(0, 11, i, i + 1, 0), 1'b1, "sweep");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
